// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: datapath width, bubble encoding and fetch FSM states.
package mips_pkg;

  localparam int unsigned PC_W = 32;

  // sll $0,$0,0
  localparam logic [PC_W-1:0] NOP_WORD = '0;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: flush inserts a bubble, load captures a fetched word, otherwise hold.
module if_id_register
  import mips_pkg::*;
#(
  parameter logic [PC_W-1:0] BUBBLE_WORD = mips_pkg::NOP_WORD
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load_i,
  input  logic            flush_i,
  input  logic [PC_W-1:0] instr_i,
  input  logic [PC_W-1:0] pcplus4_i,
  output logic [PC_W-1:0] instr_o,
  output logic [PC_W-1:0] pcplus4_o,
  output logic            valid_o
);

  logic [PC_W-1:0] instr_q;
  logic [PC_W-1:0] pcplus4_q;
  logic            valid_q;

  // A bubble leaves PC+4 untouched; it is meaningless while valid is low.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      instr_q   <= BUBBLE_WORD;
      pcplus4_q <= '0;
      valid_q   <= 1'b0;
    end else if (flush_i) begin
      instr_q <= BUBBLE_WORD;
      valid_q <= 1'b0;
    end else if (load_i) begin
      instr_q   <= instr_i;
      pcplus4_q <= pcplus4_i;
      valid_q   <= 1'b1;
    end
  end

  assign instr_o   = instr_q;
  assign pcplus4_o = pcplus4_q;
  assign valid_o   = valid_q;

endmodule

// File: rtl/instruction_fetch_stage.sv
// MIPS fetch stage: PC register, next-PC selection, fetch FSM and delivered-instruction counter.
module instruction_fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = mips_pkg::NOP_WORD,
  parameter int unsigned IMEM_AW  = 7
) (
  input  logic        Clk,
  input  logic        Reset,
  output logic [31:0] IMemAddress,
  input  logic [31:0] IMemInstruction,
  input  logic        DecodeReady,
  input  logic        RedirectValid,
  input  logic [31:0] RedirectTarget,
  input  logic        Halt,
  output logic [31:0] IFID_Instruction,
  output logic [31:0] IFID_PCPlus4,
  output logic        IFID_Valid,
  output logic        Halted,
  output logic [31:0] FetchCount
);

  // Memory word index is PC[IMEM_AW+1:2]; aliasing above that is intentional.
  if (IMEM_AW < 1 || IMEM_AW > 30) begin : g_bad_aw
    $error("IMEM_AW out of range");
  end

  localparam logic [PC_W-1:0] RESET_PC_ALIGNED = {RESET_PC[PC_W-1:2], 2'b00};

  fetch_state_e    state_q, state_d;
  logic            halted_q;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] count_q, count_d;
  logic [PC_W-1:0] pc_plus4;
  logic [PC_W-1:0] redirect_pc;
  logic            ifid_load;
  logic            ifid_flush;

  assign pc_plus4    = pc_q + 32'd4;
  assign redirect_pc = {RedirectTarget[PC_W-1:2], 2'b00};

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    count_d    = count_q;
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    unique case (state_q)
      BOOT: begin
        state_d    = RUN;
        ifid_flush = 1'b1;
        if (RedirectValid) pc_d = redirect_pc;
      end
      RUN: begin
        if (RedirectValid) begin
          pc_d       = redirect_pc;
          ifid_flush = 1'b1;
        end else if (!DecodeReady) begin
          pc_d = pc_q;
        end else if (Halt) begin
          ifid_flush = 1'b1;
          state_d    = HALTED;
        end else begin
          ifid_load = 1'b1;
          pc_d      = pc_plus4;
          count_d   = count_q + 32'd1;
        end
      end
      HALTED: begin
        if (RedirectValid) begin
          pc_d       = redirect_pc;
          ifid_flush = 1'b1;
          state_d    = RUN;
        end else if (DecodeReady) begin
          ifid_flush = 1'b1;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q  <= BOOT;
      halted_q <= 1'b0;
      pc_q     <= RESET_PC_ALIGNED;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      halted_q <= (state_d == HALTED);
      pc_q     <= pc_d;
      count_q  <= count_d;
    end
  end

  if_id_register #(
    .BUBBLE_WORD(NOP_WORD)
  ) u_if_id (
    .clk_i     (Clk),
    .rst_ni    (Reset),
    .load_i    (ifid_load),
    .flush_i   (ifid_flush),
    .instr_i   (IMemInstruction),
    .pcplus4_i (pc_plus4),
    .instr_o   (IFID_Instruction),
    .pcplus4_o (IFID_PCPlus4),
    .valid_o   (IFID_Valid)
  );

  assign IMemAddress = pc_q;
  assign Halted      = halted_q;
  assign FetchCount  = count_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: directed vector table, async-reset sequence, randomized run vs. model.
module tb_instruction_fetch_stage;

  localparam int unsigned AW  = 7;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        Clk, Reset;
  logic [31:0] IMemAddress, IMemInstruction;
  logic        DecodeReady, RedirectValid, Halt;
  logic [31:0] RedirectTarget;
  logic [31:0] IFID_Instruction, IFID_PCPlus4, FetchCount;
  logic        IFID_Valid, Halted;

  logic [31:0] mem [2**AW];
  int checks   = 0;
  int failures = 0;

  assign IMemInstruction = mem[IMemAddress[AW+1:2]];

  instruction_fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_WORD (NOP),
    .IMEM_AW  (AW)
  ) dut (
    .Clk              (Clk),
    .Reset            (Reset),
    .IMemAddress      (IMemAddress),
    .IMemInstruction  (IMemInstruction),
    .DecodeReady      (DecodeReady),
    .RedirectValid    (RedirectValid),
    .RedirectTarget   (RedirectTarget),
    .Halt             (Halt),
    .IFID_Instruction (IFID_Instruction),
    .IFID_PCPlus4     (IFID_PCPlus4),
    .IFID_Valid       (IFID_Valid),
    .Halted           (Halted),
    .FetchCount       (FetchCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic        rdy;
    logic        redir;
    logic [31:0] tgt;
    logic        halt;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
    logic [31:0] e_pc;
    logic        e_halted;
    logic [31:0] e_count;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rdy, logic redir, logic [31:0] tgt, logic halt,
                              logic v, logic [31:0] ins, logic [31:0] p4,
                              logic [31:0] pc, logic h, logic [31:0] cnt);
    vec_t r;
    r.rdy = rdy; r.redir = redir; r.tgt = tgt; r.halt = halt;
    r.e_valid = v; r.e_instr = ins; r.e_pc4 = p4; r.e_pc = pc;
    r.e_halted = h; r.e_count = cnt;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic v, input logic [31:0] ins,
                           input logic [31:0] p4, input logic [31:0] pc,
                           input logic h, input logic [31:0] cnt);
    chk({tag, ".valid"},  {31'd0, IFID_Valid}, {31'd0, v});
    chk({tag, ".instr"},  IFID_Instruction, ins);
    if (v) chk({tag, ".pc4"}, IFID_PCPlus4, p4);
    chk({tag, ".pc"},     IMemAddress, pc);
    chk({tag, ".halted"}, {31'd0, Halted}, {31'd0, h});
    chk({tag, ".count"},  FetchCount, cnt);
  endtask

  task automatic drive(input logic rdy, input logic redir, input logic [31:0] tgt, input logic halt);
    DecodeReady    = rdy;
    RedirectValid  = redir;
    RedirectTarget = tgt;
    Halt           = halt;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, ".valid"},  {31'd0, IFID_Valid}, 32'd0);
    chk({tag, ".instr"},  IFID_Instruction, NOP);
    chk({tag, ".pc4"},    IFID_PCPlus4, 32'd0);
    chk({tag, ".pc"},     IMemAddress, 32'd0);
    chk({tag, ".halted"}, {31'd0, Halted}, 32'd0);
    chk({tag, ".count"},  FetchCount, 32'd0);
  endtask

  // Reference model: observable fetch-stage behaviour as a set of priority rules.
  logic [31:0] m_pc, m_instr, m_pc4, m_count;
  logic        m_valid, m_started, m_halted;

  task automatic model_reset();
    m_pc = 32'd0; m_instr = NOP; m_pc4 = 32'd0; m_count = 32'd0;
    m_valid = 1'b0; m_started = 1'b0; m_halted = 1'b0;
  endtask

  task automatic model_step();
    logic [31:0] word;
    word = mem[m_pc[AW+1:2]];
    if (!m_started) begin
      m_started = 1'b1;
      if (RedirectValid) m_pc = RedirectTarget & ~32'd3;
      m_instr = NOP; m_valid = 1'b0;
    end else if (RedirectValid) begin
      m_pc = RedirectTarget & ~32'd3;
      m_instr = NOP; m_valid = 1'b0; m_halted = 1'b0;
    end else if (m_halted) begin
      if (DecodeReady) begin m_instr = NOP; m_valid = 1'b0; end
    end else if (!DecodeReady) begin
      // stall: nothing moves
    end else if (Halt) begin
      m_instr = NOP; m_valid = 1'b0; m_halted = 1'b1;
    end else begin
      m_instr = word; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
      m_pc = m_pc + 32'd4; m_count = m_count + 32'd1;
    end
  endtask

  initial begin
    vec_t v;
    Reset = 1'b0;
    drive(1'b0, 1'b0, 32'd0, 1'b0);
    for (int unsigned i = 0; i < 2**AW; i++) mem[i] = i * 3;

    tbl.push_back(mk(1,0,32'h0,0,         0,NOP,   32'h0,  32'h0,  0,0));
    tbl.push_back(mk(1,0,32'h0,0,         1,32'd0, 32'h4,  32'h4,  0,1));
    tbl.push_back(mk(1,0,32'h0,0,         1,32'd3, 32'h8,  32'h8,  0,2));
    tbl.push_back(mk(1,0,32'h0,0,         1,32'd6, 32'hC,  32'hC,  0,3));
    tbl.push_back(mk(1,0,32'h0,0,         1,32'd9, 32'h10, 32'h10, 0,4));
    tbl.push_back(mk(0,0,32'h0,0,         1,32'd9, 32'h10, 32'h10, 0,4));
    tbl.push_back(mk(0,0,32'h0,0,         1,32'd9, 32'h10, 32'h10, 0,4));
    tbl.push_back(mk(0,0,32'h0,0,         1,32'd9, 32'h10, 32'h10, 0,4));
    tbl.push_back(mk(1,0,32'h0,0,         1,32'd12,32'h14, 32'h14, 0,5));
    tbl.push_back(mk(1,1,32'h42,0,        0,NOP,   32'h0,  32'h40, 0,5));
    tbl.push_back(mk(1,0,32'h0,0,         1,32'd48,32'h44, 32'h44, 0,6));
    tbl.push_back(mk(0,1,32'h80,0,        0,NOP,   32'h0,  32'h80, 0,6));
    tbl.push_back(mk(1,0,32'h0,0,         1,32'd96,32'h84, 32'h84, 0,7));
    tbl.push_back(mk(1,1,32'h23,0,        0,NOP,   32'h0,  32'h20, 0,7));
    tbl.push_back(mk(1,0,32'h0,1,         0,NOP,   32'h0,  32'h20, 1,7));
    tbl.push_back(mk(1,0,32'h0,0,         0,NOP,   32'h0,  32'h20, 1,7));
    tbl.push_back(mk(1,0,32'h0,1,         0,NOP,   32'h0,  32'h20, 1,7));
    tbl.push_back(mk(0,0,32'h0,0,         0,NOP,   32'h0,  32'h20, 1,7));
    tbl.push_back(mk(1,0,32'h0,1,         0,NOP,   32'h0,  32'h20, 1,7));
    tbl.push_back(mk(1,0,32'h0,0,         0,NOP,   32'h0,  32'h20, 1,7));
    tbl.push_back(mk(1,1,32'h0,0,         0,NOP,   32'h0,  32'h0,  0,7));
    tbl.push_back(mk(1,0,32'h0,0,         1,32'd0, 32'h4,  32'h4,  0,8));
    tbl.push_back(mk(1,1,32'h100,1,       0,NOP,   32'h0,  32'h100,0,8));
    tbl.push_back(mk(1,0,32'h0,0,         1,32'd192,32'h104,32'h104,0,9));
    tbl.push_back(mk(1,1,32'h204,0,       0,NOP,   32'h0,  32'h204,0,9));
    tbl.push_back(mk(1,0,32'h0,0,         1,32'd3, 32'h208,32'h208,0,10));
    tbl.push_back(mk(0,0,32'h0,1,         1,32'd3, 32'h208,32'h208,0,10));
    tbl.push_back(mk(1,1,32'hFFFF_FFFF,0, 0,NOP,   32'h0,  32'hFFFF_FFFC,0,10));
    tbl.push_back(mk(1,0,32'h0,0,         1,32'd381,32'h0, 32'h0,  0,11));

    repeat (2) @(negedge Clk);
    #1 check_reset_values("reset");
    Reset = 1'b1;

    foreach (tbl[i]) begin
      v = tbl[i];
      drive(v.rdy, v.redir, v.tgt, v.halt);
      @(posedge Clk); #1;
      check_all($sformatf("vec%0d", i), v.e_valid, v.e_instr, v.e_pc4, v.e_pc, v.e_halted, v.e_count);
      @(negedge Clk);
    end

    // Asynchronous reset between edges, then the boot sequence again.
    drive(1'b1, 1'b0, 32'd0, 1'b0);
    repeat (3) @(negedge Clk);
    #2 Reset = 1'b0;
    #1 check_reset_values("async_rst");
    #1 Reset = 1'b1;
    @(posedge Clk); #1 check_all("restart1", 1'b0, NOP, 32'h0, 32'h0, 1'b0, 32'd0);
    @(posedge Clk); #1 check_all("restart2", 1'b1, 32'd0, 32'h4, 32'h4, 1'b0, 32'd1);
    @(posedge Clk); #1 check_all("restart3", 1'b1, 32'd3, 32'h8, 32'h8, 1'b0, 32'd2);
    @(negedge Clk);

    for (int unsigned i = 0; i < 2**AW; i++) mem[i] = $urandom;
    Reset = 1'b0;
    #1 Reset = 1'b1;
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        #1 Reset = 1'b0;
        #1 Reset = 1'b1;
        model_reset();
      end
      drive($urandom_range(0, 3) != 0,
            $urandom_range(0, 15) == 0,
            ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 1023)),
            $urandom_range(0, 19) == 0);
      model_step();
      @(posedge Clk); #1;
      check_all($sformatf("rnd%0d", n), m_valid, m_instr, m_pc4, m_pc, m_halted, m_count);
      @(negedge Clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
